// File: rtl/sdp_erdma_eg_ro_dfifo_ctrl.sv
// Egress read-out data FIFO: DEPTH x DW flop storage with valid/ready on both sides.
// Optional same-cycle write-to-read bypass when empty: define SDP_ERDMA_DFIFO_BYPASS_EN.
module sdp_erdma_eg_ro_dfifo_ctrl #(
  parameter int DEPTH = 4,
  parameter int DW    = 256
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic [31:0]   pwrbus_ram_pd,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [3:0]    fifo_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_FULL = 4'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [3:0]    cnt;
  logic          empty;
  logic          full;
  logic          bypass;
  logic          push;
  logic          pop;

  // Power-down hint has no functional effect on flop storage.
  logic unused_pwrbus;
  assign unused_pwrbus = ^pwrbus_ram_pd;

  assign empty    = (cnt == 4'd0);
  assign full     = (cnt == CNT_FULL);
  assign fifo_cnt = cnt;

  // Ready depends only on stored state, so a same-cycle pop never frees a full FIFO.
  assign wr_prdy = ~full;

`ifdef SDP_ERDMA_DFIFO_BYPASS_EN
  // Empty with a ready consumer: the beat flows straight through and is never stored.
  assign bypass  = empty & rd_prdy;
  assign rd_pvld = ~empty | (bypass & wr_pvld);
  assign rd_pd   = bypass ? wr_pd : mem[rd_ptr];
`else
  assign bypass  = 1'b0;
  assign rd_pvld = ~empty;
  assign rd_pd   = mem[rd_ptr];
`endif

  assign push = wr_pvld & wr_prdy & ~bypass;
  assign pop  = rd_pvld & rd_prdy & ~bypass;

  // NOTE: storage has no reset; validity is tracked by cnt, so stale entries are never exposed.
  always_ff @(posedge nvdla_core_clk) begin
    if (push && !nvdla_core_rst) begin
      mem[wr_ptr] <= wr_pd;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= 4'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + 4'(push) - 4'(pop);
    end
  end

endmodule

// File: tb/tb_sdp_erdma_eg_ro_dfifo_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue model.
module tb_sdp_erdma_eg_ro_dfifo_ctrl;

  localparam int DEPTH = 4;
  localparam int DW    = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   pwrbus_ram_pd = '0;
  logic          wr_pvld = 1'b0;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd = '0;
  logic          rd_pvld;
  logic          rd_prdy = 1'b0;
  logic [DW-1:0] rd_pd;
  logic [3:0]    fifo_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] q[$];

  always #5 clk = ~clk;

  sdp_erdma_eg_ro_dfifo_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .pwrbus_ram_pd (pwrbus_ram_pd),
    .wr_pvld       (wr_pvld),
    .wr_prdy       (wr_prdy),
    .wr_pd         (wr_pd),
    .rd_pvld       (rd_pvld),
    .rd_prdy       (rd_prdy),
    .rd_pd         (rd_pd),
    .fifo_cnt      (fifo_cnt)
  );

  function automatic bit byp_now();
`ifdef SDP_ERDMA_DFIFO_BYPASS_EN
    return (q.size() == 0) && rd_prdy;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_wr_prdy();
    return q.size() != DEPTH;
  endfunction

  function automatic bit exp_rd_pvld();
    return (q.size() != 0) || (byp_now() && wr_pvld);
  endfunction

  function automatic logic [DW-1:0] exp_rd_pd();
    return (q.size() != 0) ? q[0] : wr_pd;
  endfunction

  function automatic logic [DW-1:0] rand_pd();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Advance one clock edge and apply the transfer rules to the reference queue.
  task automatic tick();
    bit byp, do_push, do_pop;
    @(posedge clk);
    byp     = byp_now();
    do_push = wr_pvld && (q.size() != DEPTH) && !byp;
    do_pop  = rd_prdy && (q.size() != 0) && !byp;
    if (rst) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(wr_pd);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_pvld = 1'b0; rd_prdy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #3;
    n_cmp++; if (fifo_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", fifo_cnt); end
    n_cmp++; if (rd_pvld !== 1'b0) begin n_err++; $display("FAIL reset_rd_pvld: got %b want 0", rd_pvld); end
    n_cmp++; if (wr_prdy !== 1'b1) begin n_err++; $display("FAIL reset_wr_prdy: got %b want 1", wr_prdy); end
  endtask

  task automatic test_fill();
    logic [DW-1:0] pats [4];
    pats[0] = {32{8'hA5}}; pats[1] = {32{8'h5A}}; pats[2] = {32{8'h11}}; pats[3] = {32{8'h22}};
    rd_prdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_pvld = 1'b1; wr_pd = pats[i];
      #3;
      n_cmp++; if (wr_prdy !== 1'b1) begin n_err++; $display("FAIL fill_wr_prdy[%0d]: got %b want 1", i, wr_prdy); end
      tick();
    end
    wr_pd = {32{8'h33}};
    #3;
    n_cmp++; if (fifo_cnt !== 4'd4) begin n_err++; $display("FAIL fill_cnt: got %0d want 4", fifo_cnt); end
    n_cmp++; if (wr_prdy !== 1'b0) begin n_err++; $display("FAIL full_wr_prdy: got %b want 0", wr_prdy); end
    tick();
    #3;
    n_cmp++; if (fifo_cnt !== 4'd4) begin n_err++; $display("FAIL full_hold_cnt: got %0d want 4", fifo_cnt); end
    n_cmp++; if (rd_pd !== {32{8'hA5}}) begin n_err++; $display("FAIL full_head: got %h want %h", rd_pd, {32{8'hA5}}); end
  endtask

  task automatic test_drain_from_full();
    logic [DW-1:0] pats [4];
    int guard;
    pats[0] = {32{8'hA5}}; pats[1] = {32{8'h5A}}; pats[2] = {32{8'h11}}; pats[3] = {32{8'h22}};
    wr_pvld = 1'b1; wr_pd = {32{8'h33}}; rd_prdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      n_cmp++; if (rd_pvld !== 1'b1) begin n_err++; $display("FAIL drain_pvld[%0d]: got %b want 1", i, rd_pvld); end
      n_cmp++; if (rd_pd !== pats[i]) begin n_err++; $display("FAIL drain_pd[%0d]: got %h want %h", i, rd_pd, pats[i]); end
      n_cmp++; if (wr_prdy !== (i != 0)) begin n_err++; $display("FAIL drain_wr_prdy[%0d]: got %b want %b", i, wr_prdy, (i != 0)); end
      tick();
    end
    #3;
    n_cmp++; if (fifo_cnt !== 4'(q.size())) begin n_err++; $display("FAIL drain_cnt: got %0d want %0d", fifo_cnt, q.size()); end
    n_cmp++; if (rd_pd !== {32{8'h33}}) begin n_err++; $display("FAIL drain_33: got %h want %h", rd_pd, {32{8'h33}}); end
    wr_pvld = 1'b0;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      #3;
      n_cmp++; if (rd_pd !== exp_rd_pd()) begin n_err++; $display("FAIL flush_pd: got %h want %h", rd_pd, exp_rd_pd()); end
      tick();
      guard++;
    end
    #3;
    n_cmp++; if (rd_pvld !== 1'b0 || guard >= 20) begin n_err++; $display("FAIL flush_empty: pvld %b guard %0d", rd_pvld, guard); end
  endtask

  task automatic test_stream();
    int n;
    logic [3:0] want_cnt;
    n = 2 * DEPTH + 3;
    rd_prdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      wr_pvld = 1'b1; wr_pd = DW'(1000 + i);
      #3;
`ifdef SDP_ERDMA_DFIFO_BYPASS_EN
      want_cnt = 4'd0;
`else
      want_cnt = (i == 0) ? 4'd0 : 4'd1;
`endif
      n_cmp++; if (fifo_cnt !== want_cnt) begin n_err++; $display("FAIL stream_cnt[%0d]: got %0d want %0d", i, fifo_cnt, want_cnt); end
      if (i != 0) begin
        n_cmp++; if (rd_pd !== DW'(1000 + i - 1) && rd_pd !== DW'(1000 + i)) begin n_err++; $display("FAIL stream_range[%0d]: got %h", i, rd_pd); end
      end
      if (exp_rd_pvld()) begin
        n_cmp++; if (rd_pd !== exp_rd_pd()) begin n_err++; $display("FAIL stream_pd[%0d]: got %h want %h", i, rd_pd, exp_rd_pd()); end
      end
      tick();
    end
    wr_pvld = 1'b0;
    #3;
    if (q.size() != 0) begin
      n_cmp++; if (rd_pd !== DW'(1000 + n - 1)) begin n_err++; $display("FAIL stream_last: got %h want %h", rd_pd, DW'(1000 + n - 1)); end
    end
    tick();
    #3;
    n_cmp++; if (fifo_cnt !== 4'd0) begin n_err++; $display("FAIL stream_end_cnt: got %0d want 0", fifo_cnt); end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] v;
    v = {8{32'hDEADBEEF}};
    rd_prdy = 1'b1; wr_pvld = 1'b1; wr_pd = v;
    #3;
`ifdef SDP_ERDMA_DFIFO_BYPASS_EN
    n_cmp++; if (rd_pvld !== 1'b1) begin n_err++; $display("FAIL byp_pvld: got %b want 1", rd_pvld); end
    n_cmp++; if (rd_pd !== v) begin n_err++; $display("FAIL byp_pd: got %h want %h", rd_pd, v); end
`else
    n_cmp++; if (rd_pvld !== 1'b0) begin n_err++; $display("FAIL nobyp_pvld: got %b want 0", rd_pvld); end
`endif
    tick();
    wr_pvld = 1'b0; wr_pd = '0;
    #3;
`ifdef SDP_ERDMA_DFIFO_BYPASS_EN
    n_cmp++; if (fifo_cnt !== 4'd0) begin n_err++; $display("FAIL byp_cnt: got %0d want 0", fifo_cnt); end
`else
    n_cmp++; if (fifo_cnt !== 4'd1) begin n_err++; $display("FAIL nobyp_cnt: got %0d want 1", fifo_cnt); end
    n_cmp++; if (rd_pvld !== 1'b1 || rd_pd !== v) begin n_err++; $display("FAIL nobyp_next: pvld %b got %h want %h", rd_pvld, rd_pd, v); end
`endif
    tick();
    #3;
    n_cmp++; if (fifo_cnt !== 4'd0) begin n_err++; $display("FAIL byp_end_cnt: got %0d want 0", fifo_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] v;
    rd_prdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_pvld = 1'b1; wr_pd = rand_pd();
      tick();
    end
    #3;
    n_cmp++; if (fifo_cnt !== 4'd3) begin n_err++; $display("FAIL rmid_pre_cnt: got %0d want 3", fifo_cnt); end
    rst = 1'b1; wr_pvld = 1'b1; wr_pd = rand_pd();
    tick();
    rst = 1'b0; wr_pvld = 1'b0;
    #3;
    n_cmp++; if (fifo_cnt !== 4'd0) begin n_err++; $display("FAIL rmid_cnt: got %0d want 0", fifo_cnt); end
    n_cmp++; if (rd_pvld !== 1'b0) begin n_err++; $display("FAIL rmid_pvld: got %b want 0", rd_pvld); end
    n_cmp++; if (wr_prdy !== 1'b1) begin n_err++; $display("FAIL rmid_wr_prdy: got %b want 1", wr_prdy); end
    v = rand_pd();
    wr_pvld = 1'b1; wr_pd = v;
    tick();
    wr_pvld = 1'b0; rd_prdy = 1'b1;
    #3;
    n_cmp++; if (rd_pvld !== 1'b1 || rd_pd !== v) begin n_err++; $display("FAIL rmid_read: pvld %b got %h want %h", rd_pvld, rd_pd, v); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wr_pvld = ($urandom_range(0, 99) < 60);
      rd_prdy = ($urandom_range(0, 99) < 50);
      wr_pd   = rand_pd();
      #3;
      n_cmp++; if (wr_prdy !== exp_wr_prdy()) begin n_err++; $display("FAIL rnd_wr_prdy[%0d]: got %b want %b", i, wr_prdy, exp_wr_prdy()); end
      n_cmp++; if (rd_pvld !== exp_rd_pvld()) begin n_err++; $display("FAIL rnd_rd_pvld[%0d]: got %b want %b", i, rd_pvld, exp_rd_pvld()); end
      n_cmp++; if (fifo_cnt !== 4'(q.size())) begin n_err++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, fifo_cnt, q.size()); end
      if (exp_rd_pvld()) begin
        n_cmp++; if (rd_pd !== exp_rd_pd()) begin n_err++; $display("FAIL rnd_pd[%0d]: got %h want %h", i, rd_pd, exp_rd_pd()); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_from_full();
    test_stream();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdp_erdma_eg_ro_dfifo_ctrl.md
SDP_ERDMA_EG_RO_DFIFO_CTRL -- requirements
Module: sdp_erdma_eg_ro_dfifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, number of 256-bit storage entries; legal values 2, 4, 8.
REQ-002 Parameter DW, default 256, payload width in bits.
REQ-003 nvdla_core_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 nvdla_core_rst  input  1  synchronous reset, active-high.
REQ-005 pwrbus_ram_pd  input  32  RAM power-down bus; accepted and ignored functionally.
REQ-006 wr_pvld  input  1  write-side valid.
REQ-007 wr_prdy  output  1  write-side ready; high when a push can be accepted this cycle.
REQ-008 wr_pd  input  DW  write payload.
REQ-009 rd_pvld  output  1  read-side valid.
REQ-010 rd_prdy  input  1  read-side ready from consumer.
REQ-011 rd_pd  output  DW  read payload, held stable while rd_pvld high and rd_prdy low.
REQ-012 fifo_cnt  output  4  number of stored entries, 0..DEPTH.

Function
REQ-013 Push when wr_pvld and wr_prdy both high; pop when rd_pvld and rd_prdy both high.
REQ-014 wr_prdy SHALL equal (fifo_cnt != DEPTH); it is combinational from state only, never from rd_prdy.
REQ-015 rd_pvld SHALL equal (fifo_cnt != 0), except as extended by REQ-024.
REQ-016 Storage: DEPTH x DW flop array; push writes entry at wr_ptr; rd_pd is combinational mux of entry at rd_ptr.
REQ-017 wr_ptr and rd_ptr are log2(DEPTH)-bit counters, incremented on push/pop respectively, wrapping DEPTH-1 -> 0.
REQ-018 fifo_cnt next = cnt + push - pop; simultaneous push and pop leaves cnt unchanged and both pointers advance.
REQ-019 Write-to-read latency (bypass disabled): data pushed in cycle N is visible on rd_pd with rd_pvld in cycle N+1.
REQ-020 Full: push blocked; a pop in the same cycle does not enable a push that cycle; wr_prdy rises the cycle after the pop.
REQ-021 Empty: no pop occurs; rd_pd value is don't-care while rd_pvld is low.
REQ-022 Ordering strictly FIFO; no entry dropped or duplicated across pointer wrap.

Reset
REQ-023 While nvdla_core_rst high at a clock edge: wr_ptr, rd_ptr, fifo_cnt <- 0; rd_pvld = 0 and wr_prdy = 1 from the following cycle; storage contents not reset; reset mid-transfer discards all stored entries and any same-cycle push.

Configuration
REQ-024 Macro SDP_ERDMA_DFIFO_BYPASS_EN defined: when fifo_cnt == 0 and rd_prdy high, rd_pvld = wr_pvld and rd_pd = wr_pd combinationally; the beat transfers in the same cycle and is not stored (cnt and pointers unchanged); when fifo_cnt == 0 and rd_prdy low, a push is stored normally.
REQ-025 Macro undefined: no combinational wr-to-rd path exists; behaviour per REQ-019 only.

Verification
REQ-026 Reset then idle: fifo_cnt=0, rd_pvld=0, wr_prdy=1 on first cycle after reset release.
REQ-027 Push 0xA5..A5, 0x5A..5A, 0x11..11, 0x22..22 with rd_prdy=0 -> fifo_cnt=4, wr_prdy=0; fifth push 0x33..33 held and not accepted.
REQ-028 From full, rd_prdy=1 for 4 cycles with wr_pvld=1 (0x33..33 held) -> reads 0xA5..,0x5A..,0x11..,0x22.. in order; 0x33.. accepted the cycle after first pop.
REQ-029 Continuous push and pop for 2*DEPTH+3 beats of incrementing data -> fifo_cnt stays at 1 after first push, all data read in order across pointer wrap.
REQ-030 Macro defined, empty, rd_prdy=1, push 0xDEAD..BEEF -> rd_pvld=1 and rd_pd=0xDEAD..BEEF same cycle, fifo_cnt stays 0; macro undefined -> visible next cycle, fifo_cnt=1 then 0.
REQ-031 Assert reset with fifo_cnt=3 and simultaneous push -> next cycle fifo_cnt=0, rd_pvld=0, wr_prdy=1; subsequent push reads back correctly.
